// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Load/store request and response channels between the core
//               (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked data-memory target. One request at a time, RV32I
//               byte/half/word loads and stores, programmable wait states,
//               response held until the requester takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero latency the commit happens on the accept edge itself, so the
  // live bus inputs stand in for the captured request while idle.
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_we;
  logic [2:0]  cur_f3;
  assign cur_addr  = (state == IDLE) ? bus.req_addr   : cap_addr;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata  : cap_wdata;
  assign cur_we    = (state == IDLE) ? bus.req_we     : cap_we;
  assign cur_f3    = (state == IDLE) ? bus.req_funct3 : cap_f3;

  logic [AW-1:0] idx;
  logic          out_of_range;
  assign idx          = cur_addr[AW+1:2];
  assign out_of_range = |cur_addr[31:AW+2];

  // Decode legality of size/sign code, alignment and direction.
  logic decode_bad;
  always_comb begin
    decode_bad = 1'b0;
    case (cur_f3)
      3'b000:  decode_bad = 1'b0;
      3'b001:  decode_bad = cur_addr[0];
      3'b010:  decode_bad = (cur_addr[1:0] != 2'b00);
      3'b100:  decode_bad = cur_we;
      3'b101:  decode_bad = cur_we | cur_addr[0];
      default: decode_bad = 1'b1;
    endcase
  end

  logic bad;
  assign bad = decode_bad | out_of_range;

  // Load path: pick the lane, shift it to bit 0 and extend.
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] rdata_next;
  assign rd_word = mem[idx];
  assign shifted = rd_word >> {cur_addr[1:0], 3'b000};
  always_comb begin
    load_data = 32'd0;
    case (cur_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end
  assign rdata_next = (bad || cur_we) ? 32'd0 : load_data;

  // Store path: replicate the right-aligned data and enable only its lanes.
  logic [3:0]  be;
  logic [31:0] wlanes;
  always_comb begin
    be     = 4'b1111;
    wlanes = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        be     = 4'b0001 << cur_addr[1:0];
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = cur_wdata;
      end
    endcase
  end

  // Commit on the edge that enters RESP; a reset on that edge drops it.
  logic commit;
  logic store_en;
  assign commit   = !rst && (((state == IDLE) && bus.req_valid && !HAS_WAIT) ||
                             ((state == WAIT) && (cnt == 4'd0)));
  assign store_en = commit && cur_we && !bad;

  // Byte-enabled storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
    end
  end

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_we    <= bus.req_we;
            cap_f3    <= bus.req_funct3;
            ready_q   <= 1'b0;
            if (HAS_WAIT) begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end else begin
              state   <= RESP;
              valid_q <= 1'b1;
              rdata_q <= rdata_next;
              err_q   <= bad;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            valid_q <= 1'b1;
            rdata_q <= rdata_next;
            err_q   <= bad;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed, table-driven bench for dmem_responder: one
//               LATENCY=2 instance for function/errors/backpressure/reset and
//               one LATENCY=0 instance for back-to-back traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if ifa();
  dmem_if ifb();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  // One transaction on the LATENCY=2 instance, optionally backpressured.
  task automatic run_a(input vec_t v, input string tag);
    int n;
    logic [31:0] rd0;
    logic        er0;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(ifa.req_ready), 32'd1);
    ifa.req_valid  = 1'b1;
    ifa.req_we     = v.we;
    ifa.req_funct3 = v.f3;
    ifa.req_addr   = v.addr;
    ifa.req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    ifa.req_valid  = 1'b0;
    ifa.req_addr   = 32'h0000_0004;
    ifa.req_we     = ~v.we;
    ifa.req_funct3 = 3'b010;
    ifa.req_wdata  = 32'h0BAD_0BAD;
    n = 0;
    @(negedge clk);
    while (!ifa.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd2);
    if (ifa.rsp_valid) begin
      chk({tag, " rdata"}, ifa.rsp_rdata, v.exp_rdata);
      chk({tag, " err"}, 32'(ifa.rsp_err), 32'(v.exp_err));
      chk({tag, " req_ready busy"}, 32'(ifa.req_ready), 32'd0);
      rd0 = ifa.rsp_rdata;
      er0 = ifa.rsp_err;
      for (int i = 0; i < v.hold; i++) begin
        ifa.req_valid  = (i == 1);
        ifa.req_we     = 1'b1;
        ifa.req_funct3 = 3'b010;
        ifa.req_addr   = v.addr;
        ifa.req_wdata  = 32'd0;
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
        @(negedge clk);
        chk({tag, " hold valid"}, 32'(ifa.rsp_valid), 32'd1);
        chk({tag, " hold rdata"}, ifa.rsp_rdata, rd0);
        chk({tag, " hold err"}, 32'(ifa.rsp_err), 32'(er0));
        chk({tag, " hold req_ready"}, 32'(ifa.req_ready), 32'd0);
      end
      ifa.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      ifa.rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, " rsp_valid drop"}, 32'(ifa.rsp_valid), 32'd0);
      chk({tag, " req_ready back"}, 32'(ifa.req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int nresp;
    int rcyc[3];
    logic [31:0] rdat[3];
    logic rerr[3];
    logic seen;

    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_funct3 = 3'b010;
    ifa.req_addr = 32'd0; ifa.req_wdata = 32'd0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_funct3 = 3'b010;
    ifb.req_addr = 32'd0; ifb.req_wdata = 32'd0; ifb.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset a req_ready", 32'(ifa.req_ready), 32'd1);
    chk("reset a rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("reset a rdata", ifa.rsp_rdata, 32'd0);
    chk("reset a err", 32'(ifa.rsp_err), 32'd0);
    chk("reset b req_ready", 32'(ifb.req_ready), 32'd1);
    chk("reset b rsp_valid", 32'(ifb.rsp_valid), 32'd0);

    //            we    f3      addr          wdata         exp_rdata     err  hold
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 0});
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 0});
    vecs.push_back('{1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF55, 32'h0000_0000, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_55EF, 1'b0, 5});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FFDE, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0000_0000, 32'h0000_00DE, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_DEAD, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0010, 32'h0000_0000, 32'h0000_55EF, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0012, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0011, 32'h0000_1234, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_55EF, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{1'b0, 3'b011, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{1'b0, 3'b110, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{1'b1, 3'b100, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hBEEF_55EF, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0011, 32'h0000_0000, 32'h0000_0055, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0010, 32'h0000_0000, 32'h0000_55EF, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_FFEF, 1'b0, 0});
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0FFC, 32'h0102_0304, 32'h0000_0000, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0FFC, 32'h0000_0000, 32'h0000_0004, 1'b0, 0});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0FFE, 32'h0000_0000, 32'h0000_0102, 1'b0, 0});

    foreach (vecs[i]) run_a(vecs[i], $sformatf("vec%0d", i));

    // Reset during WAIT of a store: the store must be dropped.
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_funct3 = 3'b010;
    ifa.req_addr = 32'h0000_0020; ifa.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    ifa.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifa.rsp_valid) seen = 1'b1;
    end
    chk("abort rsp_valid never", 32'(seen), 32'd0);
    chk("abort req_ready", 32'(ifa.req_ready), 32'd1);
    run_a('{1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0, 0}, "abort reload");

    // Zero-latency instance: back-to-back with rsp_ready tied high.
    ifb.rsp_ready = 1'b1;
    idx = 0;
    nresp = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ifb.rsp_valid && nresp < 3) begin
        rcyc[nresp] = c;
        rdat[nresp] = ifb.rsp_rdata;
        rerr[nresp] = ifb.rsp_err;
        nresp++;
      end
      if (ifb.req_ready) begin
        if (idx == 0) begin
          ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_funct3 = 3'b010;
          ifb.req_addr = 32'h0000_0008; ifb.req_wdata = 32'hCAFE_F00D;
        end else if (idx == 1) begin
          ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_funct3 = 3'b010;
          ifb.req_addr = 32'h0000_0008; ifb.req_wdata = 32'h0;
        end else if (idx == 2) begin
          ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_funct3 = 3'b001;
          ifb.req_addr = 32'h0000_000A; ifb.req_wdata = 32'h0;
        end else begin
          ifb.req_valid = 1'b0;
        end
        idx++;
      end
    end
    ifb.rsp_ready = 1'b0;
    chk("b2b response count", 32'(nresp), 32'd3);
    if (nresp == 3) begin
      chk("b2b first latency", 32'(rcyc[0]), 32'd1);
      chk("b2b spacing 1", 32'(rcyc[1] - rcyc[0]), 32'd2);
      chk("b2b spacing 2", 32'(rcyc[2] - rcyc[1]), 32'd2);
      chk("b2b store rdata", rdat[0], 32'h0000_0000);
      chk("b2b load rdata", rdat[1], 32'hCAFE_F00D);
      chk("b2b lh rdata", rdat[2], 32'hFFFF_CAFE);
      chk("b2b err", 32'({rerr[0], rerr[1], rerr[2]}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
